accel_fill: RTL and testbench

Avalon-MM write-side companion to the dot-product read accelerator. Software programs a destination address, a start value, a step and a word count through the slave CSR port. The block then streams an arithmetic sequence (value, value+step, …) into SDRAM over its Avalon master as back-to-back 32-bit writes. It fills the operand vectors that the dot-product unit later reads, and sits on the same HPS-to-FPGA bridge and SDRAM master port.

---
 rtl/accel_fill_if.sv | 22 ++
 rtl/accel_fill.sv | 137 +++++++++++++
 tb/tb_accel_fill.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_fill_if.sv
// Avalon-MM bus bundle shared by the fill engine's master and CSR slave ports.
// AW sets the address width (32 for the SDRAM master, 3 for the CSR window).
interface accel_fill_if #(
    parameter int unsigned AW = 32
);
    logic [AW-1:0] address;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          write;
    logic          read;
    logic          waitrequest;

    modport master (
        output address, writedata, write, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, write, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/accel_fill.sv
// Arithmetic-sequence fill engine: streams value, value+step, ... into memory over an
// Avalon master, programmed and monitored through a small Avalon CSR slave.
module accel_fill (
    input  logic         clk,
    input  logic         rst_n,
    accel_fill_if.master m_bus,
    accel_fill_if.slave  s_bus
);
    typedef enum logic {ST_IDLE, ST_WRITE} state_e;

    state_e      state_q, state_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] base_q, base_d;
    logic [31:0] step_q, step_d;
    logic [31:0] n_q, n_d;
    logic [31:0] progress_q, progress_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rem_q, rem_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic        busy, ctrl_wr, start_req, abort_req, accept;
    logic [31:0] rdata;
    logic        unused_ok;

    assign unused_ok = ^{m_bus.readdata, s_bus.read};

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        base_d     = base_q;
        step_d     = step_q;
        n_d        = n_q;
        progress_d = progress_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rem_d      = rem_q;
        done_d     = done_q;
        abort_d    = abort_q;

        busy      = (state_q == ST_WRITE);
        ctrl_wr   = s_bus.write && (s_bus.address == 3'd0);
        start_req = ctrl_wr && s_bus.writedata[0];
        // Abort is only meaningful on its own; a combined start+abort write drops the abort bit.
        abort_req = ctrl_wr && s_bus.writedata[1] && !s_bus.writedata[0];
        accept    = busy && !m_bus.waitrequest;

        if (s_bus.write && !busy) begin
            case (s_bus.address)
                3'd1:    dst_d  = s_bus.writedata;
                3'd2:    base_d = s_bus.writedata;
                3'd3:    step_d = s_bus.writedata;
                3'd4:    n_d    = s_bus.writedata;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    progress_d = '0;
                    addr_d     = dst_q;
                    data_d     = base_q;
                    rem_d      = n_q;
                    if (n_q != '0) begin
                        state_d = ST_WRITE;
                        done_d  = 1'b0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (abort_req) abort_d = 1'b1;
                if (accept) begin
                    addr_d     = addr_q + 32'd4;
                    data_d     = data_q + step_q;
                    rem_d      = rem_q - 32'd1;
                    progress_d = progress_q + 32'd1;
                    // An abort landing on the accept edge still stops before the next word.
                    if (rem_q == 32'd1 || abort_q || abort_req) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (s_bus.address)
            3'd0:    rdata = {30'b0, done_q, busy};
            3'd1:    rdata = dst_q;
            3'd2:    rdata = base_q;
            3'd3:    rdata = step_q;
            3'd4:    rdata = n_q;
            3'd5:    rdata = progress_q;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dst_q      <= '0;
            base_q     <= '0;
            step_q     <= '0;
            n_q        <= '0;
            progress_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            base_q     <= base_d;
            step_q     <= step_d;
            n_q        <= n_d;
            progress_q <= progress_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign m_bus.address     = addr_q;
    assign m_bus.writedata   = data_q;
    assign m_bus.write       = (state_q == ST_WRITE);
    assign m_bus.read        = 1'b0;
    assign s_bus.readdata    = rdata;
    assign s_bus.waitrequest = 1'b0;
endmodule

// File: tb/tb_accel_fill.sv
// Directed bench for accel_fill: CSR table checks plus hand-timed fill, stall,
// zero-length, abort, wraparound and mid-run reset sequences.
module tb_accel_fill;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    accel_fill_if #(.AW(32)) m_bus ();
    accel_fill_if #(.AW(3))  s_bus ();

    accel_fill dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m_bus (m_bus),
        .s_bus (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    // Accepted-word monitor; DUT state updates via NBAs so pre-edge values are seen here.
    always @(posedge clk) begin
        if (rst_n && m_bus.write && !m_bus.waitrequest) begin
            q_addr.push_back(m_bus.address);
            q_data.push_back(m_bus.writedata);
            q_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    csr_vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; the write is sampled on the next rising edge.
    task automatic csr_write(input logic [2:0] idx, input logic [31:0] val);
        s_bus.address   = idx;
        s_bus.writedata = val;
        s_bus.write     = 1'b1;
        @(negedge clk);
        s_bus.write     = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] idx, output logic [31:0] val);
        s_bus.address = idx;
        s_bus.read    = 1'b1;
        #1;
        val           = s_bus.readdata;
        s_bus.read    = 1'b0;
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] st;
        int n;
        n = 0;
        csr_read(3'd0, st);
        while (st[0] && n < budget) begin
            @(negedge clk);
            csr_read(3'd0, st);
            n++;
        end
        check("wait_idle_timeout", {31'b0, st[0]}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int errs;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        m_bus.readdata    = '0;
        m_bus.waitrequest = 1'b0;
        s_bus.address     = '0;
        s_bus.writedata   = '0;
        s_bus.write       = 1'b0;
        s_bus.read        = 1'b0;

        vecs[0] = '{3'd1, 32'h0000_1000, 32'h0000_1000};
        vecs[1] = '{3'd2, 32'd5,         32'd5};
        vecs[2] = '{3'd3, 32'd3,         32'd3};
        vecs[3] = '{3'd4, 32'd4,         32'd4};
        vecs[4] = '{3'd6, 32'h0000_DEAD, 32'd0};
        vecs[5] = '{3'd7, 32'h0000_BEEF, 32'd0};
        vecs[6] = '{3'd5, 32'h0000_1234, 32'd0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_write", {31'b0, m_bus.write}, 32'd0);
        check("rst_m_address", m_bus.address, 32'd0);
        check("rst_m_writedata", m_bus.writedata, 32'd0);
        check("rst_m_read", {31'b0, m_bus.read}, 32'd0);
        check("rst_s_wait", {31'b0, s_bus.waitrequest}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            csr_read(i[2:0], rd);
            check($sformatf("rst_csr%0d", i), rd, 32'd0);
        end

        // CSR table: write, read back
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            csr_write(vecs[i].idx, vecs[i].wdata);
            csr_read(vecs[i].idx, rd);
            check($sformatf("csr_vec%0d", i), rd, vecs[i].exp);
        end

        // Abort while idle is ignored
        csr_write(3'd0, 32'd2);
        csr_read(3'd0, rd);
        check("idle_abort_status", rd, 32'd0);
        check("idle_abort_mwrite", {31'b0, m_bus.write}, 32'd0);

        // Basic fill: DST=0x1000 BASE=5 STEP=3 N=4
        clear_q();
        csr_write(3'd0, 32'd1);
        csr_read(3'd0, rd);
        check("basic_status_t1", rd, 32'd1);
        check("basic_addr_t1", m_bus.address, 32'h1000);
        check("basic_data_t1", m_bus.writedata, 32'd5);
        check("basic_write_t1", {31'b0, m_bus.write}, 32'd1);
        repeat (3) @(negedge clk);
        check("basic_write_tN", {31'b0, m_bus.write}, 32'd1);
        @(negedge clk);
        csr_read(3'd0, rd);
        check("basic_status_end", rd, 32'd2);
        check("basic_write_end", {31'b0, m_bus.write}, 32'd0);
        csr_read(3'd5, rd);
        check("basic_progress", rd, 32'd4);
        check("basic_count", q_addr.size(), 32'd4);
        if (q_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("basic_addr%0d", i), q_addr[i], 32'h1000 + 32'(4 * i));
                check($sformatf("basic_data%0d", i), q_data[i], 32'd5 + 32'(3 * i));
            end
            check("basic_span", 32'(q_cyc[3] - q_cyc[0]), 32'd3);
        end

        // Stall: word 2 waits 3 cycles
        clear_q();
        csr_write(3'd0, 32'd1);
        @(negedge clk);
        m_bus.waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_bus.waitrequest = 1'b0;
            #1;
            check($sformatf("stall_addr_c%0d", i), m_bus.address, 32'h1004);
            check($sformatf("stall_data_c%0d", i), m_bus.writedata, 32'd8);
            check($sformatf("stall_write_c%0d", i), {31'b0, m_bus.write}, 32'd1);
            if (i < 3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        csr_read(3'd0, rd);
        check("stall_status", rd, 32'd2);
        check("stall_count", q_addr.size(), 32'd4);
        if (q_addr.size() == 4) begin
            errs = 0;
            for (int i = 0; i < 4; i++) begin
                if (q_addr[i] !== 32'h1000 + 32'(4 * i)) errs++;
                if (q_data[i] !== 32'd5 + 32'(3 * i)) errs++;
            end
            check("stall_words", errs, 32'd0);
            check("stall_span", 32'(q_cyc[3] - q_cyc[0]), 32'd6);
        end

        // Zero length
        clear_q();
        csr_write(3'd4, 32'd0);
        csr_write(3'd0, 32'd1);
        check("zero_mwrite", {31'b0, m_bus.write}, 32'd0);
        csr_read(3'd0, rd);
        check("zero_status", rd, 32'd2);
        csr_read(3'd5, rd);
        check("zero_progress", rd, 32'd0);
        repeat (3) @(negedge clk);
        check("zero_count", q_addr.size(), 32'd0);

        // Abort while word 3 is stalled
        clear_q();
        csr_write(3'd4, 32'd100);
        csr_write(3'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
        m_bus.waitrequest = 1'b1;
        #1;
        check("abort_addr_w3", m_bus.address, 32'h1008);
        csr_write(3'd0, 32'd2);
        csr_read(3'd0, rd);
        check("abort_status_pending", rd, 32'd1);
        m_bus.waitrequest = 1'b0;
        @(negedge clk);
        check("abort_mwrite_drop", {31'b0, m_bus.write}, 32'd0);
        csr_read(3'd0, rd);
        check("abort_status", rd, 32'd2);
        csr_read(3'd5, rd);
        check("abort_progress", rd, 32'd3);
        repeat (3) @(negedge clk);
        check("abort_count", q_addr.size(), 32'd3);
        if (q_data.size() == 3) check("abort_last_data", q_data[2], 32'd11);

        // Full 100-word run after the abort
        clear_q();
        csr_write(3'd0, 32'd1);
        wait_idle(300);
        csr_read(3'd5, rd);
        check("full_progress", rd, 32'd100);
        check("full_count", q_addr.size(), 32'd100);
        if (q_addr.size() == 100) begin
            errs = 0;
            for (int i = 0; i < 100; i++) begin
                if (q_addr[i] !== 32'h1000 + 32'(4 * i)) errs++;
                if (q_data[i] !== 32'd5 + 32'(3 * i)) errs++;
            end
            check("full_words", errs, 32'd0);
        end

        // Wraparound and busy lockout
        clear_q();
        csr_write(3'd1, 32'hFFFF_FFFC);
        csr_write(3'd2, 32'hFFFF_FFFF);
        csr_write(3'd3, 32'd1);
        csr_write(3'd4, 32'd2);
        csr_write(3'd0, 32'd1);
        csr_write(3'd1, 32'h0000_0055);
        @(negedge clk);
        csr_read(3'd0, rd);
        check("wrap_status", rd, 32'd2);
        csr_read(3'd1, rd);
        check("wrap_dst_locked", rd, 32'hFFFF_FFFC);
        check("wrap_count", q_addr.size(), 32'd2);
        if (q_addr.size() == 2) begin
            check("wrap_addr0", q_addr[0], 32'hFFFF_FFFC);
            check("wrap_data0", q_data[0], 32'hFFFF_FFFF);
            check("wrap_addr1", q_addr[1], 32'h0000_0000);
            check("wrap_data1", q_data[1], 32'h0000_0000);
        end

        // Mid-transfer reset
        csr_write(3'd1, 32'h0000_2000);
        csr_write(3'd2, 32'd7);
        csr_write(3'd4, 32'd10);
        csr_write(3'd0, 32'd1);
        @(negedge clk);
        clear_q();
        rst_n = 1'b0;
        #1;
        check("mrst_mwrite", {31'b0, m_bus.write}, 32'd0);
        check("mrst_maddr", m_bus.address, 32'd0);
        check("mrst_mdata", m_bus.writedata, 32'd0);
        csr_read(3'd0, rd);
        check("mrst_status", rd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            csr_read(i[2:0], rd);
            check($sformatf("mrst_csr%0d", i), rd, 32'd0);
        end
        repeat (5) @(negedge clk);
        check("mrst_no_writes", q_addr.size(), 32'd0);
        check("mrst_mwrite_after", {31'b0, m_bus.write}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
